// File: rtl/move_input_ctrl.sv
// Push-button front end for the game controller: synchronises and debounces
// left/right/confirm, keeps the column cursor and issues per-player confirm pulses.
module move_input_ctrl #(
    parameter int unsigned NUM_COLS        = 7,
    parameter int unsigned COL_W           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RESET_COL       = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_confirm,
    input  logic [1:0]       current_player,
    input  logic             game_over,
    output logic [COL_W-1:0] column_select,
    output logic             confirm_move1,
    output logic             confirm_move2
);

    localparam int unsigned NUM_BTN   = 3;
    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_CONF  = 2;
    localparam int unsigned CNT_W     = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_READY,
        ST_FIRE,
        ST_HOLD,
        ST_WAIT_RELEASE,
        ST_LOCKED
    } state_t;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] rise;
    logic               conf_level;
    logic [1:0]         sync_vld;

    state_t             state;
    state_t             state_next;
    logic [COL_W-1:0]   col_next;
    logic [COL_W-1:0]   col_inc;
    logic [COL_W-1:0]   col_dec;
    logic               move_ok;
    logic               p1_next;
    logic               p2_next;

    assign raw = {btn_confirm, btn_right, btn_left};

    // Marks the point where the synchroniser outputs reflect real samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_vld <= 2'b00;
        end else begin
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        logic             s1;
        logic             s2;
        logic             lvl;
        logic             lvl_q;
        logic             armed;
        logic [CNT_W-1:0] cnt;

        // Two-flop sync, debounce counter, edge history and a post-reset arm:
        // a button held through reset must read low once before it can fire.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                lvl   <= 1'b0;
                lvl_q <= 1'b0;
                armed <= 1'b0;
                cnt   <= '0;
            end else begin
                s1    <= raw[b];
                s2    <= s1;
                lvl_q <= lvl;
                if (s2 == lvl) begin
                    cnt <= '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                    lvl <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (sync_vld[1] && !s2 && !lvl) begin
                    armed <= 1'b1;
                end
            end
        end

        assign rise[b] = lvl & ~lvl_q & armed;

        if (b == BTN_CONF) begin : g_conf_level
            assign conf_level = lvl;
        end
    end

    assign col_inc = (column_select == COL_W'(NUM_COLS - 1)) ? '0 : column_select + COL_W'(1);
    assign col_dec = (column_select == '0) ? COL_W'(NUM_COLS - 1) : column_select - COL_W'(1);

    // Next state, cursor and pulse decode; game_over overrides everything
    always_comb begin
        state_next = state;
        col_next   = column_select;
        p1_next    = 1'b0;
        p2_next    = 1'b0;
        move_ok    = 1'b0;

        case (state)
            ST_READY: begin
                if (rise[BTN_CONF]) begin
                    if (current_player == 2'b01 || current_player == 2'b10) begin
                        state_next = ST_FIRE;
                        p1_next    = (current_player == 2'b01);
                        p2_next    = (current_player == 2'b10);
                    end else begin
                        state_next = ST_WAIT_RELEASE;
                    end
                end else begin
                    move_ok = 1'b1;
                end
            end
            ST_FIRE: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                state_next = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                move_ok = 1'b1;
                if (!conf_level) begin
                    state_next = ST_READY;
                end
            end
            ST_LOCKED: begin
                state_next = ST_LOCKED;
            end
            default: begin
                state_next = ST_LOCKED;
            end
        endcase

        if (move_ok && (rise[BTN_LEFT] ^ rise[BTN_RIGHT])) begin
            col_next = rise[BTN_LEFT] ? col_dec : col_inc;
        end

        if (game_over) begin
            state_next = ST_LOCKED;
            col_next   = column_select;
            p1_next    = 1'b0;
            p2_next    = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_READY;
            column_select <= COL_W'(RESET_COL);
            confirm_move1 <= 1'b0;
            confirm_move2 <= 1'b0;
        end else begin
            state         <= state_next;
            column_select <= col_next;
            confirm_move1 <= p1_next;
            confirm_move2 <= p2_next;
        end
    end

endmodule

// File: doc/move_input_ctrl.md
Name: move_input_ctrl

Overview:
- Front-end stage directly upstream of the game control FSM.
- Takes raw push-buttons (left, right, confirm), synchronises and debounces them, and maintains a column cursor.
- Emits a one-cycle confirm pulse for the player whose turn it is. Outputs feed the control block's column_select, confirm_move1 and confirm_move2 inputs.
- Locks all input once game_over is asserted.

Parameters:
- NUM_COLS, 7, number of board columns; cursor range 0..NUM_COLS-1.
- COL_W, 3, width of column_select; must satisfy 2^COL_W >= NUM_COLS.
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required to change a debounced level (board build overrides to about 500000).
- RESET_COL, 3, cursor value after reset.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- btn_left  input  1  raw button, active-high, asynchronous to clk.
- btn_right  input  1  raw button, active-high, asynchronous to clk.
- btn_confirm  input  1  raw button, active-high, asynchronous to clk.
- current_player  input  2  from the control block; 2'b01 = player 1, 2'b10 = player 2.
- game_over  input  1  from the control block; level.
- column_select  output  COL_W  registered cursor column.
- confirm_move1  output  1  registered one-cycle pulse, player 1 confirm.
- confirm_move2  output  1  registered one-cycle pulse, player 2 confirm.

Behaviour:
- Reset (reset=0, async):
  - column_select=RESET_COL; confirm_move1=confirm_move2=0.
  - Synchroniser flops, debounced levels and debounce counters cleared to 0.
  - FSM enters READY.
  - A reset asserted mid-pulse clears the pulse in the same instant. No pulse is produced on reset release, even if a button is held; the button must first read debounced-low.
- Synchroniser: two flops per button.
- Debounce, per button:
  - The counter increments while the synchronised value differs from the debounced level, and clears when it matches.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no level change.
- Event: a 0->1 transition of a debounced level is a one-cycle internal event. 1->0 transitions produce no event.
- Latency: button rising at sample edge 0 and held stable gives:
  - debounced level high at edge 2+DEBOUNCE_CYCLES;
  - confirm pulse (or cursor update) visible after edge 3+DEBOUNCE_CYCLES.
- Cursor:
  - Left event: decrement, with NUM_COLS-1 <- 0 wrap.
  - Right event: increment, with 0 <- NUM_COLS-1 wrap.
  - Left and right events in the same cycle: no change.
  - Cursor updates are allowed only in READY and WAIT_RELEASE.
- FSM states: READY, FIRE, HOLD, WAIT_RELEASE, LOCKED.
  - READY: a confirm event with current_player=01 or 10 -> FIRE.
    - A confirm event with current_player=00 or 11 is ignored, and the FSM goes to WAIT_RELEASE.
    - If a left/right event and a confirm event arrive in the same cycle, confirm wins and the cursor does not move.
  - FIRE (exactly 1 cycle): asserts confirm_move1 if current_player=01, or confirm_move2 if 10, using the value sampled at the event. Never both. Next state HOLD.
  - HOLD (1 cycle): no pulse; column_select frozen, which covers the control block's CHECK_MOVE cycle. Next state WAIT_RELEASE.
  - WAIT_RELEASE: stays until debounced confirm=0, then -> READY.
    - A held confirm button therefore yields exactly one pulse.
    - Cursor moves are permitted in this state.
  - LOCKED: entered from any state on the first edge with game_over=1. This has priority over every transition, and an in-flight pulse is not issued if game_over is already 1.
    - In LOCKED: no pulses, cursor frozen.
    - Exit only via reset.
- column_select is constant from the edge that raises a confirm pulse through the end of HOLD.
- The minimum spacing between two confirm pulses is 3 cycles plus the release and re-press debounce time.

Test Plan:
- Reset with reset=0, release, no buttons -> column_select=3, both confirms 0, held for 20 cycles.
- Right pressed 4 times (each held DEBOUNCE_CYCLES+3, released) from 3 -> column_select 4,5,6,0. Then left once -> 6.
- current_player=01, confirm held 30 cycles -> confirm_move1 high exactly 1 cycle, 7 cycles after the first high sample; confirm_move2 never high.
- Repeat with current_player=10 at column 5 -> single confirm_move2 pulse with column_select=5 on the pulse cycle and the following cycle.
- Confirm glitch of DEBOUNCE_CYCLES-1 cycles -> no pulse, no state change. Left and right pressed on the same cycle -> cursor unchanged.
- game_over=1, then presses on all buttons -> no pulses, cursor frozen. Assert reset=0 mid-sequence -> outputs return to reset values asynchronously, and operation resumes after release.
